// File: rtl/fm_rd_dma_req.sv
// -----------------------------------------------------------------------------
// fm_rd_dma_req
//   Read-DMA request generator for the 32->2x16 burst read splitter.
//   Walks a 2-D region (i_lines lines of i_line_words words, line pitch
//   i_stride) and issues 32-word-aligned read requests of 1..32 words. Each
//   request is held on o_req/o_adrs/o_len until i_ack. A credit counter tracks
//   words requested but not yet popped from the downstream read-data FIFO so
//   the FIFO (P_FIFO_DEPTH words) can never overflow.
//
//   Ports
//     clk_core, rst_x          core clock, asynchronous active-low reset
//     i_start                  1-cycle start pulse (ignored while busy)
//     i_abort                  stop once the request in flight is accepted
//     i_base_adrs, i_stride    first line address / line stride (bits [4:0] ignored)
//     i_line_words, i_lines    region geometry
//     i_pop                    one word consumed from the read-data FIFO
//     o_busy, o_done           transfer active / 1-cycle normal completion
//     o_req, o_adrs, o_len     request to splitter, accepted by i_ack
//
//   Optional build macro FM_RD_DMA_REQ_STAT_EN adds:
//     o_req_cnt   accepted requests since last start (saturating)
//     o_stall_cnt cycles spent waiting for credit since last start (saturating)
// -----------------------------------------------------------------------------
module fm_rd_dma_req #(
    parameter int P_ADDR_W     = 24,
    parameter int P_LEN_W      = 6,
    parameter int P_LW_W       = 12,
    parameter int P_LN_W       = 10,
    parameter int P_FIFO_DEPTH = 64,
    parameter int P_CRD_W      = 7
) (
    input  logic                clk_core,
    input  logic                rst_x,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [P_ADDR_W-1:0] i_base_adrs,
    input  logic [P_ADDR_W-1:0] i_stride,
    input  logic [P_LW_W-1:0]   i_line_words,
    input  logic [P_LN_W-1:0]   i_lines,
    input  logic                i_pop,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_req,
    output logic [P_ADDR_W-1:0] o_adrs,
    output logic [P_LEN_W-1:0]  o_len,
    input  logic                i_ack
`ifdef FM_RD_DMA_REQ_STAT_EN
    ,
    output logic [15:0]         o_req_cnt,
    output logic [15:0]         o_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_CRD,
        S_REQ
    } state_t;

    localparam logic [P_ADDR_W-1:0] ALIGN_MASK = ~P_ADDR_W'(31);

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                req_q, req_d;
    logic [P_ADDR_W-1:0] adrs_q, adrs_d;
    logic [P_LEN_W-1:0]  len_q, len_d;
    logic [P_ADDR_W-1:0] cur_adrs_q, cur_adrs_d;    // next request address
    logic [P_ADDR_W-1:0] line_adrs_q, line_adrs_d;  // start of current line
    logic [P_ADDR_W-1:0] stride_q, stride_d;
    logic [P_LW_W-1:0]   rem_q, rem_d;              // words left in current line
    logic [P_LW_W-1:0]   words_q, words_d;
    logic [P_LN_W-1:0]   lines_q, lines_d;          // lines left including current
    logic                abort_q, abort_d;          // abort seen while in REQ
    logic [P_CRD_W-1:0]  crd_q, crd_d;

    logic [P_LEN_W-1:0]  cur_len;
    logic [P_CRD_W:0]    free_words;
    logic                fits;
    logic                ack_acc;
    logic                pop_acc;
    logic [P_LW_W-1:0]   rem_next;
    logic [P_ADDR_W-1:0] next_line_adrs;

    // Request length: rest of the line, capped at one 32-word burst.
    always_comb begin
        cur_len = P_LEN_W'(32);
        if (rem_q < P_LW_W'(32)) begin
            cur_len = rem_q[P_LEN_W-1:0];
        end
    end

    assign free_words     = (P_CRD_W+1)'(P_FIFO_DEPTH) - {1'b0, crd_q};
    assign fits           = (free_words >= (P_CRD_W+1)'(cur_len));
    assign ack_acc        = (state_q == S_REQ) && i_ack;
    assign pop_acc        = i_pop && (crd_q != '0);
    assign rem_next       = rem_q - P_LW_W'(len_q);
    assign next_line_adrs = line_adrs_q + stride_q;

    // Credit: an accepted request and a pop in the same cycle net to +len-1.
    always_comb begin
        crd_d = crd_q;
        if (ack_acc) begin
            crd_d = crd_d + P_CRD_W'(len_q);
        end
        if (pop_acc) begin
            crd_d = crd_d - P_CRD_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        req_d       = req_q;
        adrs_d      = adrs_q;
        len_d       = len_q;
        cur_adrs_d  = cur_adrs_q;
        line_adrs_d = line_adrs_q;
        stride_d    = stride_q;
        rem_d       = rem_q;
        words_d     = words_q;
        lines_d     = lines_q;
        abort_d     = abort_q;

        unique case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (i_start) begin
                    if ((i_lines != '0) && (i_line_words != '0)) begin
                        state_d     = S_WAIT_CRD;
                        busy_d      = 1'b1;
                        cur_adrs_d  = i_base_adrs & ALIGN_MASK;
                        line_adrs_d = i_base_adrs & ALIGN_MASK;
                        stride_d    = i_stride & ALIGN_MASK;
                        rem_d       = i_line_words;
                        words_d     = i_line_words;
                        lines_d     = i_lines;
                    end else begin
                        // Empty region: complete immediately without a request.
                        done_d = 1'b1;
                    end
                end
            end

            S_WAIT_CRD: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (fits) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    adrs_d  = cur_adrs_q;
                    len_d   = cur_len;
                end
            end

            S_REQ: begin
                if (i_abort) begin
                    abort_d = 1'b1;
                end
                if (i_ack) begin
                    req_d      = 1'b0;
                    cur_adrs_d = cur_adrs_q + P_ADDR_W'(len_q);
                    rem_d      = rem_next;
                    if (rem_next == '0) begin
                        line_adrs_d = next_line_adrs;
                        cur_adrs_d  = next_line_adrs;
                        rem_d       = words_q;
                        lines_d     = lines_q - P_LN_W'(1);
                    end
                    // Completing the final request wins over a late abort.
                    if ((rem_next == '0) && (lines_q == P_LN_W'(1))) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (abort_q || i_abort) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_WAIT_CRD;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_core or negedge rst_x) begin
        if (!rst_x) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_q       <= 1'b0;
            adrs_q      <= '0;
            len_q       <= '0;
            cur_adrs_q  <= '0;
            line_adrs_q <= '0;
            stride_q    <= '0;
            rem_q       <= '0;
            words_q     <= '0;
            lines_q     <= '0;
            abort_q     <= 1'b0;
            crd_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            req_q       <= req_d;
            adrs_q      <= adrs_d;
            len_q       <= len_d;
            cur_adrs_q  <= cur_adrs_d;
            line_adrs_q <= line_adrs_d;
            stride_q    <= stride_d;
            rem_q       <= rem_d;
            words_q     <= words_d;
            lines_q     <= lines_d;
            abort_q     <= abort_d;
            crd_q       <= crd_d;
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_req  = req_q;
    assign o_adrs = adrs_q;
    assign o_len  = len_q;

`ifdef FM_RD_DMA_REQ_STAT_EN
    logic [15:0] req_cnt_q, req_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        req_cnt_d   = req_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_IDLE) && i_start) begin
            req_cnt_d   = '0;
            stall_cnt_d = '0;
        end else begin
            if (ack_acc && (req_cnt_q != '1)) begin
                req_cnt_d = req_cnt_q + 16'd1;
            end
            if ((state_q == S_WAIT_CRD) && !fits && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_core or negedge rst_x) begin
        if (!rst_x) begin
            req_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            req_cnt_q   <= req_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_req_cnt   = req_cnt_q;
    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fm_rd_dma_req.sv
// -----------------------------------------------------------------------------
// tb_fm_rd_dma_req
//   Self-checking bench for fm_rd_dma_req (default build, statistics disabled).
//   A table of whole-transfer vectors with hand-computed request lists, plus
//   hand-written sequences for credit stalls, abort, empty start and reset.
// -----------------------------------------------------------------------------
module tb_fm_rd_dma_req;

    logic        clk_core = 1'b0;
    logic        rst_x;
    logic        i_start;
    logic        i_abort;
    logic [23:0] i_base_adrs;
    logic [23:0] i_stride;
    logic [11:0] i_line_words;
    logic [9:0]  i_lines;
    logic        i_pop;
    logic        o_busy;
    logic        o_done;
    logic        o_req;
    logic [23:0] o_adrs;
    logic [5:0]  o_len;
    logic        i_ack;

    int unsigned checks = 0;
    int unsigned errors = 0;

    fm_rd_dma_req #(
        .P_ADDR_W     (24),
        .P_LEN_W      (6),
        .P_LW_W       (12),
        .P_LN_W       (10),
        .P_FIFO_DEPTH (64),
        .P_CRD_W      (7)
    ) dut (
        .clk_core     (clk_core),
        .rst_x        (rst_x),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_base_adrs  (i_base_adrs),
        .i_stride     (i_stride),
        .i_line_words (i_line_words),
        .i_lines      (i_lines),
        .i_pop        (i_pop),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_req        (o_req),
        .o_adrs       (o_adrs),
        .o_len        (o_len),
        .i_ack        (i_ack)
    );

    always #5 clk_core = ~clk_core;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [23:0]      base;
        logic [23:0]      stride;
        logic [11:0]      words;
        logic [9:0]       lines;
        int unsigned      ack_dly;
        int unsigned      nreq;
        logic [3:0][23:0] ea;
        logic [3:0][5:0]  el;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic start_xfer(input logic [23:0] base, input logic [23:0] stride,
                              input logic [11:0] words, input logic [9:0] lines);
        i_base_adrs  = base;
        i_stride     = stride;
        i_line_words = words;
        i_lines      = lines;
        i_start      = 1'b1;
        @(negedge clk_core);
        i_start      = 1'b0;
    endtask

    // Wait for o_req, check it, then accept it (optionally popping in the ack cycle).
    task automatic serve(input string nm, input logic [23:0] ea, input logic [5:0] el,
                         input logic with_pop);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk_core);
            seen = o_req;
        end
        chk({nm, " seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({nm, " adrs"}, 32'(o_adrs), 32'(ea));
            chk({nm, " len"}, 32'(o_len), 32'(el));
            i_ack = 1'b1;
            i_pop = with_pop;
            @(negedge clk_core);
            i_ack = 1'b0;
            i_pop = 1'b0;
        end
    endtask

    task automatic quiet(input string nm, input int unsigned n);
        logic q;
        q = 1'b1;
        repeat (n) begin
            @(negedge clk_core);
            if (o_req || o_done) q = 1'b0;
        end
        chk({nm, " quiet"}, 32'(q), 32'd1);
    endtask

    task automatic drain();
        i_pop = 1'b1;
        repeat (70) @(negedge clk_core);
        i_pop = 1'b0;
    endtask

    task automatic run_vec(input int unsigned vi);
        vec_t        v;
        int unsigned idx;
        int unsigned wcnt;
        logic        fin;
        v    = vecs[vi];
        idx  = 0;
        wcnt = 0;
        fin  = 1'b0;
        i_pop = 1'b1;
        start_xfer(v.base, v.stride, v.words, v.lines);
        for (int c = 0; c < 500 && !fin; c++) begin
            @(negedge clk_core);
            i_ack = 1'b0;
            if (o_done) begin
                fin = 1'b1;
            end else if (o_req) begin
                if (wcnt == v.ack_dly) begin
                    if (idx < v.nreq) begin
                        chk($sformatf("v%0d req%0d adrs", vi, idx), 32'(o_adrs), 32'(v.ea[idx]));
                        chk($sformatf("v%0d req%0d len", vi, idx), 32'(o_len), 32'(v.el[idx]));
                    end else begin
                        chk($sformatf("v%0d extra req", vi), idx, v.nreq);
                    end
                    idx++;
                    i_ack = 1'b1;
                    wcnt  = 0;
                end else begin
                    wcnt++;
                end
            end
        end
        i_ack = 1'b0;
        chk($sformatf("v%0d done seen", vi), 32'(fin), 32'd1);
        chk($sformatf("v%0d req count", vi), idx, v.nreq);
        chk($sformatf("v%0d busy at done", vi), 32'(o_busy), 32'd0);
        @(negedge clk_core);
        chk($sformatf("v%0d done width", vi), 32'(o_done), 32'd0);
        i_pop = 1'b0;
    endtask

    initial begin
        logic seen;
        logic stable;

        rst_x = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_pop = 1'b0; i_ack = 1'b0;
        i_base_adrs = '0; i_stride = '0; i_line_words = '0; i_lines = '0;

        // Two lines of 40 words: one full and one short burst per line.
        vecs[0].base = 24'h000100; vecs[0].stride = 24'h000040; vecs[0].words = 12'd40;
        vecs[0].lines = 10'd2; vecs[0].ack_dly = 1; vecs[0].nreq = 4;
        vecs[0].ea[0] = 24'h000100; vecs[0].el[0] = 6'd32;
        vecs[0].ea[1] = 24'h000120; vecs[0].el[1] = 6'd8;
        vecs[0].ea[2] = 24'h000140; vecs[0].el[2] = 6'd32;
        vecs[0].ea[3] = 24'h000160; vecs[0].el[3] = 6'd8;
        // Unaligned base/stride: low five bits dropped.
        vecs[1].base = 24'h00001F; vecs[1].stride = 24'h000025; vecs[1].words = 12'd5;
        vecs[1].lines = 10'd3; vecs[1].ack_dly = 0; vecs[1].nreq = 3;
        vecs[1].ea[0] = 24'h000000; vecs[1].el[0] = 6'd5;
        vecs[1].ea[1] = 24'h000020; vecs[1].el[1] = 6'd5;
        vecs[1].ea[2] = 24'h000040; vecs[1].el[2] = 6'd5;
        vecs[1].ea[3] = 24'h000000; vecs[1].el[3] = 6'd0;
        // Address wrap at the top of the 24-bit space.
        vecs[2].base = 24'hFFFFE0; vecs[2].stride = 24'h000020; vecs[2].words = 12'd33;
        vecs[2].lines = 10'd2; vecs[2].ack_dly = 2; vecs[2].nreq = 4;
        vecs[2].ea[0] = 24'hFFFFE0; vecs[2].el[0] = 6'd32;
        vecs[2].ea[1] = 24'h000000; vecs[2].el[1] = 6'd1;
        vecs[2].ea[2] = 24'h000000; vecs[2].el[2] = 6'd32;
        vecs[2].ea[3] = 24'h000020; vecs[2].el[3] = 6'd1;
        // Exact multiple of 32, single line.
        vecs[3].base = 24'h003A40; vecs[3].stride = 24'h000000; vecs[3].words = 12'd64;
        vecs[3].lines = 10'd1; vecs[3].ack_dly = 1; vecs[3].nreq = 2;
        vecs[3].ea[0] = 24'h003A40; vecs[3].el[0] = 6'd32;
        vecs[3].ea[1] = 24'h003A60; vecs[3].el[1] = 6'd32;
        vecs[3].ea[2] = 24'h000000; vecs[3].el[2] = 6'd0;
        vecs[3].ea[3] = 24'h000000; vecs[3].el[3] = 6'd0;

        repeat (3) @(negedge clk_core);
        rst_x = 1'b1;
        @(negedge clk_core);
        chk("reset busy", 32'(o_busy), 32'd0);
        chk("reset done", 32'(o_done), 32'd0);
        chk("reset req", 32'(o_req), 32'd0);
        chk("reset adrs", 32'(o_adrs), 32'd0);
        chk("reset len", 32'(o_len), 32'd0);

        for (int unsigned vi = 0; vi < 4; vi++) begin
            run_vec(vi);
        end
        drain();

        // Empty region: immediate done, no request, never busy.
        start_xfer(24'h000100, 24'h000040, 12'd8, 10'd0);
        chk("lines0 done", 32'(o_done), 32'd1);
        chk("lines0 busy", 32'(o_busy), 32'd0);
        chk("lines0 req", 32'(o_req), 32'd0);
        quiet("lines0", 5);
        start_xfer(24'h000100, 24'h000040, 12'd0, 10'd3);
        chk("words0 done", 32'(o_done), 32'd1);
        chk("words0 busy", 32'(o_busy), 32'd0);

        // Credit stall: 96 words, no pops, credit starts at 0.
        start_xfer(24'h000200, 24'h000000, 12'd96, 10'd1);
        serve("stall r0", 24'h000200, 6'd32, 1'b0);
        serve("stall r1", 24'h000220, 6'd32, 1'b0);
        // Start while busy must be ignored.
        start_xfer(24'h000800, 24'h000040, 12'd32, 10'd5);
        quiet("stall full", 20);
        chk("stall busy", 32'(o_busy), 32'd1);
        repeat (32) begin
            i_pop = 1'b1;
            @(negedge clk_core);
        end
        i_pop = 1'b0;
        chk("stall req after pops", 32'(o_req), 32'd0);
        @(negedge clk_core);
        chk("stall req released", 32'(o_req), 32'd1);
        chk("stall r2 adrs", 32'(o_adrs), 32'h240);
        chk("stall r2 len", 32'(o_len), 32'd32);
        i_ack = 1'b1;
        @(negedge clk_core);
        i_ack = 1'b0;
        chk("stall done", 32'(o_done), 32'd1);
        drain();

        // Pop and ack in the same cycle: credit 10 -> 10+32-1 = 41.
        start_xfer(24'h000300, 24'h000000, 12'd10, 10'd1);
        serve("crd10", 24'h000300, 6'd10, 1'b0);
        chk("crd10 done", 32'(o_done), 32'd1);
        start_xfer(24'h000500, 24'h000000, 12'd32, 10'd1);
        serve("crd41", 24'h000500, 6'd32, 1'b1);
        chk("crd41 done", 32'(o_done), 32'd1);
        // Free = 64-41 = 23 < 24: stall until exactly one pop.
        start_xfer(24'h000600, 24'h000000, 12'd24, 10'd1);
        quiet("crd41 hold", 10);
        i_pop = 1'b1;
        @(negedge clk_core);
        i_pop = 1'b0;
        chk("crd40 req pre", 32'(o_req), 32'd0);
        @(negedge clk_core);
        chk("crd40 req", 32'(o_req), 32'd1);
        chk("crd40 len", 32'(o_len), 32'd24);
        i_ack = 1'b1;
        @(negedge clk_core);
        i_ack = 1'b0;
        chk("crd40 done", 32'(o_done), 32'd1);
        drain();

        // Abort during REQ with a 5-cycle delayed ack.
        start_xfer(24'h000400, 24'h000000, 12'd64, 10'd1);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk_core);
            seen = o_req;
        end
        chk("abort req seen", 32'(seen), 32'd1);
        i_abort = 1'b1;
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk_core);
            if (!o_req || (o_adrs != 24'h000400) || (o_len != 6'd32)) stable = 1'b0;
        end
        chk("abort req stable", 32'(stable), 32'd1);
        i_ack = 1'b1;
        @(negedge clk_core);
        i_ack = 1'b0;
        i_abort = 1'b0;
        chk("abort req drop", 32'(o_req), 32'd0);
        chk("abort busy", 32'(o_busy), 32'd0);
        chk("abort no done", 32'(o_done), 32'd0);
        quiet("abort idle", 5);
        // Aborted request still holds 32 credits: second burst must stall.
        start_xfer(24'h000700, 24'h000000, 12'd64, 10'd1);
        serve("abort crd r0", 24'h000700, 6'd32, 1'b0);
        quiet("abort crd hold", 10);
        chk("abort crd busy", 32'(o_busy), 32'd1);
        i_abort = 1'b1;
        @(negedge clk_core);
        i_abort = 1'b0;
        chk("abort wait busy", 32'(o_busy), 32'd0);
        chk("abort wait done", 32'(o_done), 32'd0);

        // Reset mid-request: o_req drops immediately and credit clears.
        repeat (32) begin
            i_pop = 1'b1;
            @(negedge clk_core);
        end
        i_pop = 1'b0;
        start_xfer(24'h000900, 24'h000000, 12'd64, 10'd1);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk_core);
            seen = o_req;
        end
        chk("rst req seen", 32'(seen), 32'd1);
        rst_x = 1'b0;
        #1;
        chk("rst req async", 32'(o_req), 32'd0);
        chk("rst busy async", 32'(o_busy), 32'd0);
        @(negedge clk_core);
        rst_x = 1'b1;
        @(negedge clk_core);
        start_xfer(24'h000A00, 24'h000000, 12'd64, 10'd1);
        serve("rst r0", 24'h000A00, 6'd32, 1'b0);
        serve("rst r1", 24'h000A20, 6'd32, 1'b0);
        chk("rst done", 32'(o_done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
